reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 93 +++++++++
 rtl/reg_writeback.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Latency: none (types, constants and one pure function).
// Backpressure: none.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // A source index collides with a pending write only if it is a real register.
  // The zero register is never written, so it can never be a hazard.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] pend);
    return (src != ZERO_REG) && (src == pend);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of pending writebacks with per-slot valid/addr taps for hazard lookup.
// Latency: push visible at head one cycle after the accepting edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_i,
  input  wb_entry_t                          push_entry_i,
  input  logic                               pop_i,
  output wb_entry_t                          head_o,
  output logic [$clog2(DEPTH):0]             count_o,
  output logic [DEPTH-1:0]                   entry_vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]   entry_addr_o
);

  // DEPTH is a power of two, so pointers wrap naturally on overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  // Next pointer and occupancy; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; slots outside the valid window are don't-care, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_vld_o  = '0;
    entry_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset          = PW'(i) - rd_ptr_q;
      entry_vld_o[i]  = ({1'b0, offset} < count_q);
      entry_addr_o[i] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Buffers writeback results and drains them into the register file when decode is not reading.
// Latency: result accepted at edge N into an empty queue is strobed out from edge N+1 if rd_req is low.
// Backpressure: in_ready drops when the queue is full; a full queue forces a drain despite rd_req.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rd_req,
  input  logic [REG_ADDR_W-1:0]    rd_addr1,
  input  logic [REG_ADDR_W-1:0]    rd_addr2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     reg_wr,
  output logic [REG_ADDR_W-1:0]    reg_write_addr,
  output logic [DATA_W-1:0]        reg_din,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                            accept;
  logic                            push;
  logic                            pop;
  logic                            q_full;
  logic                            q_empty;
  wb_entry_t                       push_entry;
  wb_entry_t                       head;
  logic [DEPTH-1:0]                entry_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

  logic                  reg_wr_q,   reg_wr_d;
  logic [REG_ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q,  wr_data_d;

  assign q_full   = (count == FULL_CNT);
  assign q_empty  = (count == '0);

  // Writes to the zero register are accepted but never queued.
  assign in_ready = !rst && !q_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_addr != ZERO_REG);

  // Decode reads have priority, except a full queue must drain so writes never starve.
  assign pop      = !q_empty && (!rd_req || q_full);

  assign push_entry.addr = in_addr;
  assign push_entry.data = in_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .entry_vld_o  (entry_vld),
    .entry_addr_o (entry_addr)
  );

  // Strobe is a single-cycle pulse per pop; address and data hold between pops.
  always_comb begin
    reg_wr_d  = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      reg_wr_q  <= reg_wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign reg_wr         = reg_wr_q;
  assign reg_write_addr = wr_addr_q;
  assign reg_din        = wr_data_q;

  // Hazard when a source matches any queued write or the write being strobed right now.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    if (!rst) begin
      if (reg_wr_q) begin
        hazard1 = addr_hit(rd_addr1, wr_addr_q);
        hazard2 = addr_hit(rd_addr2, wr_addr_q);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_vld[i]) begin
          hazard1 = hazard1 | addr_hit(rd_addr1, entry_addr[i]);
          hazard2 = hazard2 | addr_hit(rd_addr2, entry_addr[i]);
        end
      end
    end
  end

endmodule
